// File: rtl/keypad_scanner.sv
// keypad_scanner: one-hot column scan, 2-flop row sync, ghost rejection and press/release debounce.
// Define KEYPAD_SEG_EN to add the registered hex 7-segment outputs (segment, ctrl).
module keypad_scanner #(
   parameter int unsigned ROWS     = 4,
   parameter int unsigned COLS     = 4,
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEBOUNCE = 3,
   localparam int unsigned CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ROWS-1:0]   row,
   output logic [COLS-1:0]   col,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              key_release
`ifdef KEYPAD_SEG_EN
   ,
   output logic [7:0]        segment,
   output logic [3:0]        ctrl
`endif
);

   localparam int unsigned DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CIW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {IDLE, PRESS_DBNC, HELD, RELEASE_DBNC} state_e;

   logic [ROWS-1:0]   row_s1_q, row_s2_q;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [COLS-1:0]   col_q, col_d;
   logic [CIW-1:0]    col_idx_q, col_idx_d;
   logic              seen_q, seen_d, multi_q, multi_d;
   logic [CODE_W-1:0] acc_code_q, acc_code_d;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CODE_W-1:0] cand_q, cand_d, key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d, key_release_q, key_release_d;

   logic              tc, last_col, col_hit, col_multi, scan_seen, scan_multi, scan_done, scan_key;
   logic [CODE_W-1:0] col_code, scan_code;
   logic [CNT_W-1:0]  cnt_inc;
   logic              cnt_full;

   always_comb begin
      tc        = (dwell_q == DW'(SCAN_DIV - 1));
      last_col  = (col_idx_q == CIW'(COLS - 1));
      col_hit   = 1'b0;
      col_multi = 1'b0;
      col_code  = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (row_s2_q[r]) begin
            if (col_hit) col_multi = 1'b1;
            col_hit  = 1'b1;
            col_code = CODE_W'(r * COLS + 32'(col_idx_q));
         end
      end
      // A second hit anywhere in the scan, even in a different column, makes it MULTI
      scan_seen  = seen_q | col_hit;
      scan_multi = multi_q | col_multi | (seen_q & col_hit);
      scan_code  = seen_q ? acc_code_q : col_code;
      scan_done  = tc & last_col;
      scan_key   = scan_seen & ~scan_multi;

      dwell_d    = tc ? '0 : dwell_q + DW'(1);
      col_d      = tc ? ((col_q << 1) | (col_q >> (COLS - 1))) : col_q;
      col_idx_d  = col_idx_q;
      seen_d     = seen_q;
      multi_d    = multi_q;
      acc_code_d = acc_code_q;
      if (tc) begin
         if (last_col) begin
            col_idx_d  = '0;
            seen_d     = 1'b0;
            multi_d    = 1'b0;
            acc_code_d = '0;
         end else begin
            col_idx_d  = col_idx_q + CIW'(1);
            seen_d     = scan_seen;
            multi_d    = scan_multi;
            acc_code_d = scan_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1_q   <= '0;
         row_s2_q   <= '0;
         dwell_q    <= '0;
         col_q      <= COLS'(1);
         col_idx_q  <= '0;
         seen_q     <= 1'b0;
         multi_q    <= 1'b0;
         acc_code_q <= '0;
      end else begin
         row_s1_q   <= row;
         row_s2_q   <= row_s1_q;
         dwell_q    <= dwell_d;
         col_q      <= col_d;
         col_idx_q  <= col_idx_d;
         seen_q     <= seen_d;
         multi_q    <= multi_d;
         acc_code_q <= acc_code_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cand_d        = cand_q;
      key_code_d    = key_code_q;
      key_valid_d   = 1'b0;
      key_release_d = 1'b0;
      cnt_inc       = cnt_q + CNT_W'(1);
      cnt_full      = (cnt_inc == CNT_W'(DEBOUNCE));
      if (scan_done) begin
         case (state_q)
            IDLE: if (scan_key) begin
               cand_d = scan_code;
               if (DEBOUNCE == 1) begin
                  state_d     = HELD;
                  key_code_d  = scan_code;
                  key_valid_d = 1'b1;
                  cnt_d       = '0;
               end else begin
                  state_d = PRESS_DBNC;
                  cnt_d   = CNT_W'(1);
               end
            end
            PRESS_DBNC: begin
               if (scan_key && scan_code == cand_q) begin
                  if (cnt_full) begin
                     state_d     = HELD;
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     cnt_d       = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else if (scan_key) begin
                  cand_d = scan_code;
                  cnt_d  = CNT_W'(1);
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            HELD: if (!scan_seen) begin
               if (DEBOUNCE == 1) begin
                  state_d       = IDLE;
                  key_release_d = 1'b1;
                  cnt_d         = '0;
               end else begin
                  state_d = RELEASE_DBNC;
                  cnt_d   = CNT_W'(1);
               end
            end
            RELEASE_DBNC: begin
               if (!scan_seen) begin
                  if (cnt_full) begin
                     state_d       = IDLE;
                     key_release_d = 1'b1;
                     cnt_d         = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else if (scan_key && scan_code == key_code_q) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cand_q        <= '0;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         key_release_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cand_q        <= cand_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_release_q <= key_release_d;
      end
   end

   assign col         = col_q;
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_release = key_release_q;
   assign key_held    = (state_q == HELD) || (state_q == RELEASE_DBNC);

`ifdef KEYPAD_SEG_EN
   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 8'b11111100;  4'h1: hex_seg = 8'b01100000;
         4'h2: hex_seg = 8'b11011010;  4'h3: hex_seg = 8'b11110010;
         4'h4: hex_seg = 8'b01100110;  4'h5: hex_seg = 8'b10110110;
         4'h6: hex_seg = 8'b10111110;  4'h7: hex_seg = 8'b11100000;
         4'h8: hex_seg = 8'b11111110;  4'h9: hex_seg = 8'b11110110;
         4'hA: hex_seg = 8'b11101110;  4'hB: hex_seg = 8'b00111110;
         4'hC: hex_seg = 8'b10011100;  4'hD: hex_seg = 8'b01111010;
         4'hE: hex_seg = 8'b10011110;  default: hex_seg = 8'b10001110;
      endcase
   endfunction

   logic [7:0] segment_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           segment_q <= '0;
      else if (key_valid_d) segment_q <= hex_seg(4'(key_code_d));
   end

   assign segment = segment_q;
   assign ctrl    = 4'b1110;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE=3) against a per-scan key-set model.
// Define KEYPAD_SEG_EN for both files to also check the 7-segment outputs.
module tb_keypad_scanner;
   localparam int unsigned ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 3;
   localparam int unsigned SCAN_CYC = COLS * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  row, col, key_code;
   logic        key_valid, key_held, key_release;
   logic [15:0] pressed = '0;
`ifdef KEYPAD_SEG_EN
   logic [7:0]  segment;
   logic [3:0]  ctrl;
`endif

   int n_cmp = 0, n_fail = 0;
   int obs_v, obs_r, exp_v, exp_r;
   logic obs_v_end, obs_r_end;
   // model: key currently down, accepted code, qualifying-scan streak and its candidate
   logic m_down, m_any;
   int m_code, m_streak, m_cand;

   keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
      .key_valid(key_valid), .key_held(key_held), .key_release(key_release)
`ifdef KEYPAD_SEG_EN
      , .segment(segment), .ctrl(ctrl)
`endif
   );

   always #5 clk = ~clk;

   // Physical matrix: key r*COLS+c connects row r to column c while pressed
   always_comb begin
      row = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && col[c]) row[r] = 1'b1;
   end

   function automatic logic [7:0] hex7(input int n);
      case (n)
         0: hex7 = 8'b11111100;  1: hex7 = 8'b01100000;  2: hex7 = 8'b11011010;  3: hex7 = 8'b11110010;
         4: hex7 = 8'b01100110;  5: hex7 = 8'b10110110;  6: hex7 = 8'b10111110;  7: hex7 = 8'b11100000;
         8: hex7 = 8'b11111110;  9: hex7 = 8'b11110110; 10: hex7 = 8'b11101110; 11: hex7 = 8'b00111110;
        12: hex7 = 8'b10011100; 13: hex7 = 8'b01111010; 14: hex7 = 8'b10011110; default: hex7 = 8'b10001110;
      endcase
   endfunction

   function automatic void model_reset();
      m_down = 1'b0; m_any = 1'b0; m_code = 0; m_streak = 0; m_cand = 0;
   endfunction

   function automatic void model_scan(input logic [15:0] p);
      int n, k;
      n = $countones(p);
      k = 0;
      for (int i = 0; i < 16; i++) if (p[i]) k = i;
      exp_v = 0; exp_r = 0;
      if (!m_down) begin
         if (n == 1) begin
            if (m_streak > 0 && k == m_cand) m_streak++;
            else begin m_cand = k; m_streak = 1; end
            if (m_streak == DEBOUNCE) begin
               m_down = 1'b1; m_any = 1'b1; m_code = k; m_streak = 0; exp_v = 1;
            end
         end else m_streak = 0;
      end else begin
         if (n == 0) begin
            m_streak++;
            if (m_streak == DEBOUNCE) begin m_down = 1'b0; m_streak = 0; exp_r = 1; end
         end else if (n == 1 && k == m_code) m_streak = 0;
      end
   endfunction

   // Called at the first cycle of a scan; returns at the first cycle of the next one
   task automatic do_scan(input logic [15:0] p);
      pressed = p; obs_v = 0; obs_r = 0;
      for (int i = 1; i <= SCAN_CYC; i++) begin
         @(negedge clk);
         if (key_valid)   obs_v++;
         if (key_release) obs_r++;
      end
      obs_v_end = key_valid; obs_r_end = key_release;
   endtask

   task automatic test_reset();
      pressed = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      n_cmp++; if (col !== 4'b0001) begin n_fail++; $display("FAIL reset_col0: got %b want 0001", col); end
      n_cmp++; if ({key_valid, key_held, key_release, key_code} !== 7'd0) begin n_fail++;
         $display("FAIL reset_outs: got v=%b h=%b r=%b code=%0d want all 0", key_valid, key_held, key_release, key_code); end
      repeat (4) @(negedge clk);
      n_cmp++; if (col !== 4'b0010) begin n_fail++; $display("FAIL reset_col4: got %b want 0010", col); end
      repeat (12) @(negedge clk);
      n_cmp++; if (col !== 4'b0001) begin n_fail++; $display("FAIL reset_col16: got %b want 0001", col); end
      n_cmp++; if ({key_valid, key_held, key_release, key_code} !== 7'd0) begin n_fail++;
         $display("FAIL reset_idle: got v=%b h=%b r=%b code=%0d want all 0", key_valid, key_held, key_release, key_code); end
`ifdef KEYPAD_SEG_EN
      n_cmp++; if (segment !== 8'h00 || ctrl !== 4'b1110) begin n_fail++;
         $display("FAIL reset_seg: got seg=%b ctrl=%b want 00000000/1110", segment, ctrl); end
`endif
   endtask

   task automatic test_press();
      for (int i = 0; i < 3; i++) begin
         do_scan(16'h0040); model_scan(16'h0040);
         n_cmp++; if (obs_v !== exp_v || obs_v_end !== 1'(exp_v)) begin n_fail++;
            $display("FAIL press_valid scan%0d: got %0d pulses end=%b want %0d", i, obs_v, obs_v_end, exp_v); end
         n_cmp++; if (key_held !== m_down) begin n_fail++;
            $display("FAIL press_held scan%0d: got %b want %b", i, key_held, m_down); end
      end
      n_cmp++; if (key_code !== 4'd6) begin n_fail++; $display("FAIL press_code: got %0d want 6", key_code); end
   endtask

   task automatic test_release();
      logic [15:0] seq [6] = '{16'h0, 16'h0, 16'h0040, 16'h0, 16'h0, 16'h0};
      for (int i = 0; i < 6; i++) begin
         do_scan(seq[i]); model_scan(seq[i]);
         n_cmp++; if (obs_v !== 0) begin n_fail++; $display("FAIL release_novalid scan%0d: got %0d pulses want 0", i, obs_v); end
         n_cmp++; if (obs_r !== exp_r || obs_r_end !== 1'(exp_r)) begin n_fail++;
            $display("FAIL release_pulse scan%0d: got %0d pulses end=%b want %0d", i, obs_r, obs_r_end, exp_r); end
         n_cmp++; if (key_held !== m_down) begin n_fail++;
            $display("FAIL release_held scan%0d: got %b want %b", i, key_held, m_down); end
      end
   endtask

   task automatic test_bounce();
      logic [15:0] seq [4] = '{16'h0200, 16'h0200, 16'h0, 16'h0};
      for (int i = 0; i < 4; i++) begin
         do_scan(seq[i]); model_scan(seq[i]);
         n_cmp++; if (obs_v !== exp_v || key_held !== m_down) begin n_fail++;
            $display("FAIL bounce scan%0d: got pulses=%0d held=%b want %0d/%b", i, obs_v, key_held, exp_v, m_down); end
      end
   endtask

   task automatic test_ghost();
      for (int i = 0; i < 6; i++) begin
         do_scan(i < 5 ? 16'h0003 : 16'h0000); model_scan(i < 5 ? 16'h0003 : 16'h0000);
         n_cmp++; if (obs_v !== 0 || key_held !== 1'b0) begin n_fail++;
            $display("FAIL ghost scan%0d: got pulses=%0d held=%b want 0/0", i, obs_v, key_held); end
         n_cmp++; if (key_code !== 4'(m_code)) begin n_fail++;
            $display("FAIL ghost_code scan%0d: got %0d want %0d", i, key_code, m_code); end
      end
   endtask

`ifdef KEYPAD_SEG_EN
   task automatic test_segment();
      for (int i = 0; i < 6; i++) begin
         do_scan(i < 3 ? 16'h8000 : 16'h0000); model_scan(i < 3 ? 16'h8000 : 16'h0000);
      end
      n_cmp++; if (key_code !== 4'hF || segment !== 8'b10001110 || ctrl !== 4'b1110) begin n_fail++;
         $display("FAIL seg_F: got code=%0d seg=%b ctrl=%b want 15/10001110/1110", key_code, segment, ctrl); end
   endtask
`endif

   task automatic test_random();
      logic [15:0] p, prev;
      int sel, a, b;
      prev = '0;
      for (int i = 0; i < 90; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 2)      p = '0;
         else if (sel < 6) p = prev;
         else if (sel < 9) p = 16'h1 << $urandom_range(0, 15);
         else begin
            a = $urandom_range(0, 15); b = (a + $urandom_range(1, 15)) % 16;
            p = (16'h1 << a) | (16'h1 << b);
         end
         prev = p;
         do_scan(p); model_scan(p);
         n_cmp++; if (obs_v !== exp_v || obs_v_end !== 1'(exp_v)) begin n_fail++;
            $display("FAIL rand_valid scan%0d p=%h: got %0d end=%b want %0d", i, p, obs_v, obs_v_end, exp_v); end
         n_cmp++; if (obs_r !== exp_r || obs_r_end !== 1'(exp_r)) begin n_fail++;
            $display("FAIL rand_release scan%0d p=%h: got %0d end=%b want %0d", i, p, obs_r, obs_r_end, exp_r); end
         n_cmp++; if (key_held !== m_down || key_code !== 4'(m_code)) begin n_fail++;
            $display("FAIL rand_state scan%0d p=%h: got held=%b code=%0d want %b/%0d", i, p, key_held, key_code, m_down, m_code); end
`ifdef KEYPAD_SEG_EN
         n_cmp++; if (segment !== (m_any ? hex7(m_code) : 8'h00)) begin n_fail++;
            $display("FAIL rand_seg scan%0d: got %b want %b", i, segment, m_any ? hex7(m_code) : 8'h00); end
`endif
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin do_scan('0); model_scan('0); end
      for (int i = 0; i < 2; i++) begin do_scan(16'h0008); model_scan(16'h0008); end
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({key_valid, key_held, key_release, key_code} !== 7'd0 || col !== 4'b0001) begin n_fail++;
         $display("FAIL midreset_async: got v=%b h=%b r=%b code=%0d col=%b want 0/0/0/0/0001",
                  key_valid, key_held, key_release, key_code, col); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         do_scan(i < 2 ? 16'h0008 : 16'h0000); model_scan(i < 2 ? 16'h0008 : 16'h0000);
         n_cmp++; if (obs_v !== exp_v || obs_r !== exp_r || key_held !== m_down) begin n_fail++;
            $display("FAIL midreset_after scan%0d: got v=%0d r=%0d held=%b want %0d/%0d/%b",
                     i, obs_v, obs_r, key_held, exp_v, exp_r, m_down); end
      end
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation exceeded time limit, %0d compared / %0d mismatched", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
`ifdef KEYPAD_SEG_EN
      test_segment();
`endif
      test_press();
      test_release();
      test_bounce();
      test_ghost();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
